// File: rtl/dm_stage_pkg.sv
// Shared MIPS definitions: opcodes, result tags, M/W bundle.
// Used by the MEM stage and its load extractor.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_ALU  = 2'd1;
  localparam logic [1:0] RES_DM   = 2'd2;
  localparam logic [1:0] RES_PC8  = 2'd3;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [4:0]  a3;
    logic [1:0]  res;
    logic        j_zero;
  } m_w_t;

endpackage

// File: rtl/dm_stage_if.sv
// E/M inputs and M/W outputs of the MEM stage.
// master drives the M side, slave is the stage itself.
interface dm_stage_if;
  logic [31:0] IR_M;
  logic [31:0] PC8_M;
  logic [31:0] AO_M;
  logic [31:0] RT_M;
  logic [4:0]  A3_M;
  logic [1:0]  Res_M;
  logic        j_zero_M;
  logic [31:0] IR_W;
  logic [31:0] PC8_W;
  logic [31:0] AO_W;
  logic [31:0] DR_W;
  logic [4:0]  A3_W;
  logic [1:0]  Res_W;
  logic        j_zero_W;

  modport master (
    output IR_M, PC8_M, AO_M, RT_M,
    output A3_M, Res_M, j_zero_M,
    input  IR_W, PC8_W, AO_W, DR_W,
    input  A3_W, Res_W, j_zero_W
  );

  modport slave (
    input  IR_M, PC8_M, AO_M, RT_M,
    input  A3_M, Res_M, j_zero_M,
    output IR_W, PC8_W, AO_W, DR_W,
    output A3_W, Res_W, j_zero_W
  );
endinterface

// File: rtl/dm_ext.sv
// Load extractor: picks byte/half lane from the read word
// and sign/zero extends; 0 for non-load opcodes.
module dm_ext
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [5:0]  op,
  output logic [31:0] dr
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    case (lane)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    dr = '0;
    unique case (1'b1)
      (op == OP_LW):  dr = word;
      (op == OP_LH):  dr = {{16{h[15]}}, h};
      (op == OP_LHU): dr = {16'h0, h};
      (op == OP_LB):  dr = {{24{b[7]}}, b};
      (op == OP_LBU): dr = {24'h0, b};
      default:        dr = '0;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// MIPS MEM stage: data memory, byte-enable stores, M/W register.
// Define DM_STORE_LOG_EN to print each committed store in simulation.
module dm_stage
  import mips_defs::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int ADDR_W   = $clog2(DM_WORDS)
) (
  input  logic         clk,
  input  logic         reset,
  dm_stage_if.slave    bus
);

  logic [31:0]       mem [DM_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [5:0]        op;
  logic [31:0]       rd_word;
  logic [31:0]       wd;
  logic [31:0]       merged;
  logic [31:0]       ld;
  logic [3:0]        be;
  m_w_t              mw;
  logic              unused_hi;

  assign op        = bus.IR_M[31:26];
  assign idx       = bus.AO_M[ADDR_W+1:2];
  assign rd_word   = mem[idx];
  assign unused_hi = ^bus.AO_M[31:ADDR_W+2];

  always_comb begin
    be = 4'h0;
    wd = '0;
    unique case (1'b1)
      (op == OP_SW): begin
        be = 4'hF;
        wd = bus.RT_M;
      end
      (op == OP_SH): begin
        be = bus.AO_M[1] ? 4'hC : 4'h3;
        wd = {2{bus.RT_M[15:0]}};
      end
      (op == OP_SB): begin
        be = 4'h1 << bus.AO_M[1:0];
        wd = {4{bus.RT_M[7:0]}};
      end
      default: begin
        be = 4'h0;
        wd = '0;
      end
    endcase
  end

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
  end

  dm_ext u_ext (
    .word (rd_word),
    .lane (bus.AO_M[1:0]),
    .op   (op),
    .dr   (ld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        mem[i] <= '0;
      mw <= '0;
    end else begin
      if (|be) begin
        mem[idx] <= merged;
`ifdef DM_STORE_LOG_EN
        $display("@%h: *%h <= %h", bus.PC8_M - 32'd8,
                 {bus.AO_M[31:2], 2'b00}, merged);
`else
`endif
      end
      mw <= '{ir:     bus.IR_M,
              pc8:    bus.PC8_M,
              ao:     bus.AO_M,
              dr:     ld,
              a3:     bus.A3_M,
              res:    bus.Res_M,
              j_zero: bus.j_zero_M};
    end
  end

  assign bus.IR_W     = mw.ir;
  assign bus.PC8_W    = mw.pc8;
  assign bus.AO_W     = mw.ao;
  assign bus.DR_W     = mw.dr;
  assign bus.A3_W     = mw.a3;
  assign bus.Res_W    = mw.res;
  assign bus.j_zero_W = mw.j_zero;

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: vector table driven
// through a scoreboard queue, compared one cycle later.
module tb_dm_stage;
  import mips_defs::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dm_stage_if bus ();

  dm_stage #(.DM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ir;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [31:0] rt;
    logic [4:0]  a3;
    logic [1:0]  res;
    logic        jz;
    logic [31:0] dr;
  } vec_t;

  vec_t tbl[$];
  m_w_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pc = 32'h3000;

  function automatic vec_t mk(string nm, logic [5:0] o,
                              logic [31:0] ao, logic [31:0] rt,
                              logic [31:0] dr);
    vec_t v;
    v.name = nm;
    v.rst  = 1'b0;
    v.ir   = {o, 26'h0A5_1234};
    v.pc8  = pc + 8;
    v.ao   = ao;
    v.rt   = rt;
    v.a3   = 5'(ao[4:0] ^ 5'h11);
    v.res  = (o == OP_LW) ? RES_DM : RES_ALU;
    v.jz   = ao[2];
    v.dr   = dr;
    pc     = pc + 4;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    m_w_t exp, got;
    @(negedge clk);
    reset        = v.rst;
    bus.IR_M     = v.ir;
    bus.PC8_M    = v.pc8;
    bus.AO_M     = v.ao;
    bus.RT_M     = v.rt;
    bus.A3_M     = v.a3;
    bus.Res_M    = v.res;
    bus.j_zero_M = v.jz;
    if (v.rst) exp = '0;
    else exp = '{v.ir, v.pc8, v.ao, v.dr, v.a3, v.res, v.jz};
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    got = '{bus.IR_W, bus.PC8_W, bus.AO_W, bus.DR_W,
            bus.A3_W, bus.Res_W, bus.j_zero_W};
    exp = sb_q.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got DR=%h IR=%h AO=%h A3=%h Res=%h jz=%b PC8=%h, want DR=%h IR=%h AO=%h A3=%h Res=%h jz=%b PC8=%h",
               v.name, got.dr, got.ir, got.ao, got.a3, got.res,
               got.j_zero, got.pc8, exp.dr, exp.ir, exp.ao,
               exp.a3, exp.res, exp.j_zero, exp.pc8);
    end
  endtask

  initial begin
    vec_t r;
    bus.IR_M = '0; bus.PC8_M = '0; bus.AO_M = '0;
    bus.RT_M = '0; bus.A3_M = '0; bus.Res_M = '0;
    bus.j_zero_M = 1'b0;

    r = mk("rst0", OP_SW, 32'h0, 32'h1, 32'h0);
    r.rst = 1'b1;
    tbl.push_back(r);
    tbl.push_back(r);
    tbl.push_back(mk("sw_pre", OP_SW, 32'h0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk("lw_pre", OP_LW, 32'h0, 32'h0, 32'hDEADBEEF));
    r = mk("rst_sw", OP_SW, 32'h0, 32'h11111111, 32'h0);
    r.rst = 1'b1;
    tbl.push_back(r);
    tbl.push_back(mk("lw_after_rst", OP_LW, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk("sw10", OP_SW, 32'h10, 32'h12345678, 32'h0));
    tbl.push_back(mk("lw10", OP_LW, 32'h10, 32'h0, 32'h12345678));
    tbl.push_back(mk("sw10_clr", OP_SW, 32'h10, 32'h0, 32'h0));
    tbl.push_back(mk("sb13", OP_SB, 32'h13, 32'hFFFFFFAB, 32'h0));
    tbl.push_back(mk("lw10_sb", OP_LW, 32'h10, 32'h0, 32'hAB000000));
    tbl.push_back(mk("lb13", OP_LB, 32'h13, 32'h0, 32'hFFFFFFAB));
    tbl.push_back(mk("lbu13", OP_LBU, 32'h13, 32'h0, 32'h000000AB));
    tbl.push_back(mk("lb10", OP_LB, 32'h10, 32'h0, 32'h0));
    tbl.push_back(mk("sh22", OP_SH, 32'h22, 32'h12348001, 32'h0));
    tbl.push_back(mk("lw20", OP_LW, 32'h20, 32'h0, 32'h80010000));
    tbl.push_back(mk("lh22", OP_LH, 32'h22, 32'h0, 32'hFFFF8001));
    tbl.push_back(mk("lhu22", OP_LHU, 32'h22, 32'h0, 32'h00008001));
    tbl.push_back(mk("lh23", OP_LH, 32'h23, 32'h0, 32'hFFFF8001));
    tbl.push_back(mk("lhu20", OP_LHU, 32'h20, 32'h0, 32'h0));
    tbl.push_back(mk("sb31", OP_SB, 32'h31, 32'h0000005A, 32'h0));
    tbl.push_back(mk("sh30", OP_SH, 32'h30, 32'hFFFF7FFE, 32'h0));
    tbl.push_back(mk("lw30", OP_LW, 32'h30, 32'h0, 32'h00007FFE));
    tbl.push_back(mk("lb30", OP_LB, 32'h30, 32'h0, 32'hFFFFFFFE));
    tbl.push_back(mk("sw_wrap", OP_SW, 32'h1004, 32'hCAFEF00D, 32'h0));
    tbl.push_back(mk("lw4_wrap", OP_LW, 32'h4, 32'h0, 32'hCAFEF00D));
    r = mk("add_pass", 6'h00, 32'h4, 32'h0, 32'h0);
    r.ir  = 32'h00851020;
    r.a3  = 5'd2;
    r.res = RES_ALU;
    r.jz  = 1'b1;
    tbl.push_back(r);
    tbl.push_back(mk("lw4_keep", OP_LW, 32'h4, 32'h0, 32'hCAFEF00D));
    r = mk("sw_log", OP_SW, 32'h8, 32'h5, 32'h0);
    r.pc8 = 32'h3008;
    tbl.push_back(r);
    tbl.push_back(mk("lbu8", OP_LBU, 32'h8, 32'h0, 32'h5));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
